oai31_sreg_pipe: RTL and testbench



---
 rtl/oai31_sreg_pipe_pkg.sv | 27 ++
 rtl/oai31_sreg_pipe_slot.sv | 95 +++++++++
 rtl/oai31_sreg_pipe.sv | 163 ++++++++++++++++
 tb/tb_oai31_sreg_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/oai31_sreg_pipe_pkg.sv
// oai31_sreg_pipe_pkg
//   Shared types and helpers for the registered OAI31 skid stage.
//   - state_e     : occupancy state of the 2-entry buffer
//   - NUM_ENTRIES : storage depth
//   - MAX_WIDTH   : widest legal data vector
//   - oai31_f     : bitwise ~((a1|a2|a3)&b) on MAX_WIDTH-wide vectors
package oai31_sreg_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

  localparam int NUM_ENTRIES = 2;
  localparam int MAX_WIDTH   = 32;

  function automatic logic [MAX_WIDTH-1:0] oai31_f(
    input logic [MAX_WIDTH-1:0] a1,
    input logic [MAX_WIDTH-1:0] a2,
    input logic [MAX_WIDTH-1:0] a3,
    input logic [MAX_WIDTH-1:0] b
  );
    return ~((a1 | a2 | a3) & b);
  endfunction

endpackage

// File: rtl/oai31_sreg_pipe_slot.sv
// oai31_sreg_pipe_slot
//   One storage entry of the OAI31 skid buffer. Load priority:
//   scan shift (se) > functional data (ld_fn) > peer entry (ld_peer) > hold.
//   Optional macro OAI31_SREG_PIPE_PARITY_EN adds a parity bit that follows
//   the entry's MSB in the scan chain.
// Ports:
//   clk        rising-edge clock
//   rn         synchronous active-low reset (clears entry and parity)
//   se, si     scan enable / scan input into bit 0
//   ld_fn      load fn_data (freshly evaluated OAI31 result)
//   ld_peer    load peer_data (entry-to-entry move)
//   peer_par   parity accompanying peer_data (macro only)
//   par        stored parity bit (macro only)
//   data       stored entry
//   so         last bit of this entry's scan segment
module oai31_sreg_pipe_slot
  import oai31_sreg_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             se,
  input  logic             si,
  input  logic             ld_fn,
  input  logic [WIDTH-1:0] fn_data,
  input  logic             ld_peer,
  input  logic [WIDTH-1:0] peer_data,
`ifdef OAI31_SREG_PIPE_PARITY_EN
  input  logic             peer_par,
  output logic             par,
`endif
  output logic [WIDTH-1:0] data,
  output logic             so
);

  logic [WIDTH-1:0] data_d, data_q;

`ifdef OAI31_SREG_PIPE_PARITY_EN
  logic par_d, par_q;

  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    if (se) begin
      // shift toward MSB; the parity bit sits just past the MSB
      data_d = (data_q << 1) | WIDTH'(si);
      par_d  = data_q[WIDTH-1];
    end else if (ld_fn) begin
      data_d = fn_data;
      par_d  = ^fn_data;
    end else if (ld_peer) begin
      data_d = peer_data;
      par_d  = peer_par;
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign par = par_q;
  assign so  = par_q;
`else
  always_comb begin
    data_d = data_q;
    if (se) begin
      data_d = (data_q << 1) | WIDTH'(si);
    end else if (ld_fn) begin
      data_d = fn_data;
    end else if (ld_peer) begin
      data_d = peer_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign so = data_q[WIDTH-1];
`endif

  assign data = data_q;

endmodule

// File: rtl/oai31_sreg_pipe.sv
// oai31_sreg_pipe
//   Registered, flow-controlled OAI31 stage: evaluates ZN = ~((A1|A2|A3)&B)
//   at input acceptance and holds results in a 2-entry skid buffer.
//   Storage doubles as a scan chain SI -> head -> tail -> SO.
//   Optional macro OAI31_SREG_PIPE_PARITY_EN adds per-entry parity and the
//   ZN_PAR output; the chain then grows to 2*WIDTH+2 bits.
//
//   state | meaning
//   ------+------------------------------------------
//   EMPTY | no valid entry, head holds stale data
//   ONE   | head valid, tail free
//   FULL  | head and tail valid, upstream stalled
//
// Ports:
//   CLK, RN          clock, synchronous active-low reset
//   VDD, VSS         supply pins (no logic function)
//   A1, A2, A3, B    OAI31 operands
//   IN_VLD / IN_RDY  upstream handshake
//   ZN / OUT_VLD     head entry and its valid
//   OUT_RDY          downstream accepts head
//   ZN_PAR           head parity (macro only)
//   SE, SI, SO       scan enable / in / out
module oai31_sreg_pipe
  import oai31_sreg_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  input  logic [WIDTH-1:0] B,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  output logic [WIDTH-1:0] ZN,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  input  logic             SE,
  input  logic             SI,
`ifdef OAI31_SREG_PIPE_PARITY_EN
  output logic             ZN_PAR,
`endif
  output logic             SO
);

  // supplies are carried for the macro netlist only
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  state_e state_d, state_q;

  logic             push, pop;
  logic             head_ld_fn, head_ld_peer, tail_ld_fn;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] head_data, tail_data;
  logic             head_so, tail_so;
  logic [MAX_WIDTH-1:0] res_full;

  assign res_full = oai31_f(MAX_WIDTH'(A1), MAX_WIDTH'(A2),
                            MAX_WIDTH'(A3), MAX_WIDTH'(B));
  assign result   = res_full[WIDTH-1:0];

  if (WIDTH < MAX_WIDTH) begin : g_res_pad
    logic [MAX_WIDTH-WIDTH-1:0] unused_res;
    assign unused_res = res_full[MAX_WIDTH-1:WIDTH];
  end

  // pure state decode, no input-to-output path
  assign IN_RDY  = (state_q != FULL);
  assign OUT_VLD = (state_q != EMPTY);

  assign push = IN_VLD & IN_RDY & ~SE;
  assign pop  = OUT_VLD & OUT_RDY & ~SE;

  always_comb begin
    state_d      = state_q;
    head_ld_fn   = 1'b0;
    head_ld_peer = 1'b0;
    tail_ld_fn   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d    = ONE;
          head_ld_fn = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_ld_fn = 1'b1;
        end else if (push) begin
          state_d    = FULL;
          tail_ld_fn = 1'b1;
        end else if (pop) begin
          state_d    = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d      = ONE;
          head_ld_peer = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef OAI31_SREG_PIPE_PARITY_EN
  logic head_par, tail_par;
`endif

  oai31_sreg_pipe_slot #(.WIDTH(WIDTH)) u_head (
    .clk       (CLK),
    .rn        (RN),
    .se        (SE),
    .si        (SI),
    .ld_fn     (head_ld_fn),
    .fn_data   (result),
    .ld_peer   (head_ld_peer),
    .peer_data (tail_data),
`ifdef OAI31_SREG_PIPE_PARITY_EN
    .peer_par  (tail_par),
    .par       (head_par),
`endif
    .data      (head_data),
    .so        (head_so)
  );

  // tail is only ever written with fresh results
  oai31_sreg_pipe_slot #(.WIDTH(WIDTH)) u_tail (
    .clk       (CLK),
    .rn        (RN),
    .se        (SE),
    .si        (head_so),
    .ld_fn     (tail_ld_fn),
    .fn_data   (result),
    .ld_peer   (1'b0),
    .peer_data ('0),
`ifdef OAI31_SREG_PIPE_PARITY_EN
    .peer_par  (1'b0),
    .par       (tail_par),
`endif
    .data      (tail_data),
    .so        (tail_so)
  );

  assign ZN = head_data;
  assign SO = tail_so;
`ifdef OAI31_SREG_PIPE_PARITY_EN
  assign ZN_PAR = head_par;
`endif

endmodule

// File: tb/tb_oai31_sreg_pipe.sv
// tb_oai31_sreg_pipe
//   Directed bench for oai31_sreg_pipe (WIDTH=4). Expected head values are
//   queued when a push is issued; a monitor pops and compares on every pop.
//   Bit strings below are written MSB first.
module tb_oai31_sreg_pipe;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RN  = 1'b0;
  wire          VDD = 1'b1;
  wire          VSS = 1'b0;
  logic [W-1:0] A1 = '0, A2 = '0, A3 = '0, B = '0;
  logic         IN_VLD = 1'b0, OUT_RDY = 1'b0, SE = 1'b0, SI = 1'b0;
  logic         IN_RDY, OUT_VLD, SO;
  logic [W-1:0] ZN;
`ifdef OAI31_SREG_PIPE_PARITY_EN
  logic         ZN_PAR;
`endif

  oai31_sreg_pipe #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RN      (RN),
    .VDD     (VDD),
    .VSS     (VSS),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .B       (B),
    .IN_VLD  (IN_VLD),
    .IN_RDY  (IN_RDY),
    .ZN      (ZN),
    .OUT_VLD (OUT_VLD),
    .OUT_RDY (OUT_RDY),
    .SE      (SE),
    .SI      (SI),
`ifdef OAI31_SREG_PIPE_PARITY_EN
    .ZN_PAR  (ZN_PAR),
`endif
    .SO      (SO)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: a pop happens at the next rising edge whenever these hold
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge CLK);
      if (RN && !SE && OUT_VLD && OUT_RDY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got ZN=%0h expected no valid output at %0t", ZN, $time);
        end else begin
          e = exp_q.pop_front();
          check("zn_pop", ZN, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a1, input logic [W-1:0] a2,
                      input logic [W-1:0] a3, input logic [W-1:0] b,
                      input logic [W-1:0] exp);
    int guard = 0;
    while (!IN_RDY && guard < 50) begin
      tick();
      guard++;
    end
    if (!IN_RDY) begin
      check("push_wait_rdy", IN_RDY, 1);
    end else begin
      A1 = a1; A2 = a2; A3 = a3; B = b;
      IN_VLD = 1'b1;
      exp_q.push_back(exp);
      tick();
      IN_VLD = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    OUT_RDY = 1'b1;
    while ((exp_q.size() != 0 || OUT_VLD) && guard < 50) begin
      tick();
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_vld", OUT_VLD, 0);
  endtask

  initial begin : stim
    logic [7:0] si_bits;
    logic [7:0] so_bits;

    // reset
    repeat (2) tick();
    check("rst_in_rdy", IN_RDY, 1);
    check("rst_out_vld", OUT_VLD, 0);
    check("rst_zn", ZN, 0);
    check("rst_so", SO, 0);
    RN = 1'b1;
    tick();

    // single push: ~((0001|0010|0100)&1111) = 1000
    OUT_RDY = 1'b1;
    push(4'b0001, 4'b0010, 4'b0100, 4'b1111, 4'b1000);
    check("single_vld", OUT_VLD, 1);
    tick();
    check("single_vld_drop", OUT_VLD, 0);

    // fill and backpressure
    OUT_RDY = 1'b0;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    push(4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    check("full_in_rdy", IN_RDY, 0);
    check("full_zn_head", ZN, 4'b1111);
    check("full_out_vld", OUT_VLD, 1);
    OUT_RDY = 1'b1;
    tick();
    check("fill_rdy_after_pop", IN_RDY, 1);
    tick();
    check("fill_empty", OUT_VLD, 0);

    // simultaneous push and pop in ONE: ~(1010&1010) = 0101
    OUT_RDY = 1'b0;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    OUT_RDY = 1'b1;
    push(4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0101);
    check("pp_out_vld", OUT_VLD, 1);
    check("pp_in_rdy", IN_RDY, 1);
    tick();
    check("pp_drained", OUT_VLD, 0);

`ifndef OAI31_SREG_PIPE_PARITY_EN
    // scan: load head=0011, tail=1001, then shift 8 bits in
    OUT_RDY = 1'b0;
    push(4'b1100, 4'b0000, 4'b0000, 4'b1111, 4'b0011);
    push(4'b0110, 4'b0000, 4'b0000, 4'b1111, 4'b1001);
    si_bits = 8'b1011_0010;   // first bit shifted = bit 7
    so_bits = 8'b1001_0011;   // tail MSB..LSB then head MSB..LSB
    SE = 1'b1;
    IN_VLD = 1'b1;            // must be ignored while scanning
    OUT_RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("scan_so", SO, so_bits[7-i]);
      SI = si_bits[7-i];
      tick();
      check("scan_out_vld", OUT_VLD, 1);
      check("scan_in_rdy", IN_RDY, 0);
    end
    SE = 1'b0;
    IN_VLD = 1'b0;
    SI = 1'b0;
    // head = {s5,s6,s7,s8} = 0010, tail = {s1,s2,s3,s4} = 1011
    exp_q.delete();
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1011);
    check("scan_so_after", SO, 1);
    drain();
`endif

    // reset mid-operation from FULL with IN_VLD and SE held
    OUT_RDY = 1'b0;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    push(4'b0110, 4'b0000, 4'b0000, 4'b1111, 4'b1001);
    check("pre_rst_full", IN_RDY, 0);
    RN = 1'b0;
    IN_VLD = 1'b1;
    SE = 1'b1;
    SI = 1'b1;
    tick();
    check("mid_rst_out_vld", OUT_VLD, 0);
    check("mid_rst_in_rdy", IN_RDY, 1);
    check("mid_rst_zn", ZN, 0);
    check("mid_rst_so", SO, 0);
    RN = 1'b1;
    IN_VLD = 1'b0;
    SE = 1'b0;
    SI = 1'b0;
    exp_q.delete();

    // operation resumes cleanly after reset
    OUT_RDY = 1'b0;
    push(4'b0001, 4'b0010, 4'b0100, 4'b1111, 4'b1000);
`ifdef OAI31_SREG_PIPE_PARITY_EN
    check("par_1000", ZN_PAR, 1);
`endif
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    OUT_RDY = 1'b1;
    tick();
`ifdef OAI31_SREG_PIPE_PARITY_EN
    check("par_1111", ZN_PAR, 0);
`endif
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
